// File: rtl/adder_pkg.sv
// Shared types for the adder result FIFO: operand/sum widths and the stored
// transaction record (operands, observed sum, and the sum-check verdict).
package adder_pkg;

  localparam int OPW  = 4;
  localparam int SUMW = OPW + 1;

  typedef struct packed {
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [SUMW-1:0] sum;
    logic            err;
  } adder_txn_t;

endpackage

// File: rtl/adder_result_fifo.sv
// Buffers adder results, tagging each with a sum-check verdict at push time.
// Tracks a sticky overflow flag and a saturating count of mismatched results.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = adder_pkg::OPW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [OPW-1:0]         in_a,
  input  logic [OPW-1:0]         in_b,
  input  logic [OPW:0]           in_sum,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPW-1:0]         out_a,
  output logic [OPW-1:0]         out_b,
  output logic [OPW:0]           out_sum,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             err_cnt,
  input  logic                   clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is taken from registered count only.
  adder_txn_t    mem [DEPTH];
  adder_txn_t    wr_txn;
  adder_txn_t    head;
  logic          push;
  logic          pop;
  logic          sum_err;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Carry bit is part of the comparison, so both sides are OPW+1 bits wide.
  assign sum_err   = (in_sum != ({1'b0, in_a} + {1'b0, in_b}));

  always_comb begin
    wr_txn     = '0;
    wr_txn.a   = in_a;
    wr_txn.b   = in_b;
    wr_txn.sum = in_sum;
    wr_txn.err = sum_err;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;

    overflow_d = overflow_q | (in_valid && !in_ready);
    err_cnt_d  = err_cnt_q;
    if (push && sum_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    // Clear wins over a same-cycle set or increment.
    if (clr) begin
      overflow_d = 1'b0;
      err_cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_txn;
    end
  end

  assign head     = mem[rptr_q];
  assign out_a    = out_valid ? head.a   : '0;
  assign out_b    = out_valid ? head.b   : '0;
  assign out_sum  = out_valid ? head.sum : '0;
  assign out_err  = out_valid ? head.err : 1'b0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_adder_result_fifo;

  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int SUMW  = OPW + 1;
  localparam int W     = 2 * OPW + SUMW + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [OPW-1:0]  in_a, in_b;
  logic [SUMW-1:0] in_sum;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  out_a, out_b;
  logic [SUMW-1:0] out_sum;
  logic            out_err;
  logic [2:0]      count;
  logic            overflow;
  logic [7:0]      err_cnt;
  logic            clr;

  always #5 clk = ~clk;

  adder_result_fifo #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_sum(out_sum),
    .out_err(out_err), .count(count), .overflow(overflow), .err_cnt(err_cnt),
    .clr(clr)
  );

  // Reference model: queue of {a, b, sum, err}, sticky flag, saturating counter.
  logic [W-1:0] exp_q[$];
  bit           m_ovf;
  int           m_errcnt;
  int           n_vec;
  int           n_err;

  function automatic logic [W-1:0] model_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  task automatic drive_cycle(input logic v, input logic [OPW-1:0] a,
                             input logic [OPW-1:0] b, input logic [SUMW-1:0] s,
                             input logic r, input logic c);
    bit full, do_pop, do_push, e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sum    = s;
    out_ready = r;
    clr       = c;
    full    = (exp_q.size() == DEPTH);
    do_pop  = r && (exp_q.size() != 0);
    do_push = v && !full;
    e       = (int'(s) != int'(a) + int'(b));
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({a, b, s, e});
    if (c) begin
      m_ovf    = 1'b0;
      m_errcnt = 0;
    end else begin
      if (v && full) m_ovf = 1'b1;
      if (do_push && e && m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sum = '0;
    out_ready = 1'b0; clr = 1'b0;
    exp_q.delete(); m_ovf = 1'b0; m_errcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if ({overflow, err_cnt} !== 9'd0) begin n_err++; $display("FAIL reset_status got ovf=%b err_cnt=%0d want 0/0", overflow, err_cnt); end
    n_vec++; if ({out_a, out_b, out_sum, out_err} !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", {out_a, out_b, out_sum, out_err}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_a = 4'b1010; in_b = 4'b0101; in_sum = 5'b01111; out_ready = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got out_valid=%b want 0", out_valid); end
    drive_cycle(1'b1, 4'b1010, 4'b0101, 5'b01111, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_vec++; if (out_sum !== 5'b01111) begin n_err++; $display("FAIL basic_sum got %b want 01111", out_sum); end
    n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL basic_err got %b want 0", out_err); end
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", count); end
    n_vec++; if ({out_a, out_b} !== 8'b1010_0101) begin n_err++; $display("FAIL basic_ops got %b want 10100101", {out_a, out_b}); end
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_vec++; if (count !== 3'd0 || out_sum !== 5'd0) begin n_err++; $display("FAIL basic_pop got count=%0d sum=%b want 0/0", count, out_sum); end
  endtask

  task automatic test_err_and_carry();
    drive_cycle(1'b1, 4'b1100, 4'b0011, 5'b00000, 1'b0, 1'b0);
    n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", out_err); end
    n_vec++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL err_cnt got %0d want 1", err_cnt); end
    drive_cycle(1'b1, 4'b1111, 4'b0001, 5'b10000, 1'b1, 1'b0);
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL carry_count got %0d want 1", count); end
    n_vec++; if (out_err !== 1'b0 || out_sum !== 5'b10000) begin n_err++; $display("FAIL carry_err got err=%b sum=%b want 0/10000", out_err, out_sum); end
    n_vec++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL carry_err_cnt got %0d want 1", err_cnt); end
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [W-1:0]    pushed[$];
    logic [OPW-1:0]  a, b;
    logic [SUMW-1:0] s;
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = SUMW'(a) + SUMW'(b);
      pushed.push_back({a, b, s, 1'b0});
      drive_cycle(1'b1, a, b, s, 1'b0, 1'b0);
    end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready got %b want 0", in_ready); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({out_a, out_b, out_sum, out_err} !== pushed[i]) begin
        n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", i, {out_a, out_b, out_sum, out_err}, pushed[i]);
      end
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got count=%0d valid=%b want 0/0", count, out_valid); end
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL pop_empty got count=%0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] a, b;
    for (int i = 0; i < 2; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      drive_cycle(1'b1, a, b, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      drive_cycle(1'b1, a, b, 5'($urandom_range(0, 31)), 1'b1, 1'b0);
      n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 2", i, count); end
      n_vec++;
      if ({out_a, out_b, out_sum, out_err} !== model_head()) begin
        n_err++; $display("FAIL b2b_head[%0d] got %h want %h", i, {out_a, out_b, out_sum, out_err}, model_head());
      end
    end
  endtask

  task automatic test_clr();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clr_pre_ovf got %b want 1", overflow); end
    drive_cycle(1'b1, 4'b1100, 4'b0011, 5'b00000, 1'b0, 1'b1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", overflow); end
    n_vec++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt); end
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL clr_count got %0d want 3", count); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", out_valid); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    exp_q.delete(); m_ovf = 1'b0; m_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic            v, r, c;
    logic [OPW-1:0]  a, b;
    logic [SUMW-1:0] s;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 31) == 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : SUMW'(a) + SUMW'(b);
      if (exp_q.size() == DEPTH && v) r = 1'b0;
      drive_cycle(v, a, b, s, r, c);
      n_vec++; if (count !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, exp_q.size()); end
      n_vec++; if (out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got %b", i, out_valid); end
      n_vec++; if (in_ready !== (exp_q.size() != DEPTH)) begin n_err++; $display("FAIL rnd_ready[%0d] got %b", i, in_ready); end
      n_vec++;
      if ({out_a, out_b, out_sum, out_err} !== model_head()) begin
        n_err++; $display("FAIL rnd_head[%0d] got %h want %h", i, {out_a, out_b, out_sum, out_err}, model_head());
      end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, overflow, m_ovf); end
      n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_err++; $display("FAIL rnd_err_cnt[%0d] got %0d want %0d", i, err_cnt, m_errcnt); end
    end
  endtask

  task automatic test_saturate();
    logic [OPW-1:0] a, b;
    drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      drive_cycle(1'b1, a, b, SUMW'(a) + SUMW'(b) + SUMW'(1), 1'b1, 1'b0);
    end
    n_vec++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_err_cnt got %0d want 255", err_cnt); end
    n_vec++; if (err_cnt !== 8'(m_errcnt)) begin n_err++; $display("FAIL sat_model got %0d want %0d", err_cnt, m_errcnt); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_err_and_carry();
    test_overflow();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
